// File: rtl/aes_spi_master.sv
// SPI master that shifts {key, message, direction byte} into an AES accelerator,
// waits for its done flag and reads back the 128-bit translated block.
module aes_spi_master #(
  parameter int unsigned K       = 192,
  parameter int unsigned DIV     = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K-1:0]   key,
  input  logic [127:0]   message,
  input  logic           dir,
  output logic           sclk,
  output logic           mosi,
  output logic           ce,
  input  logic           miso,
  input  logic           done_in,
  output logic           busy,
  output logic [127:0]   result,
  output logic           result_valid,
  output logic           timeout_err
);

  localparam int unsigned N  = K + 136;
  localparam int unsigned HW = 10;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (TW > 10) ? TW : 10;
  localparam logic [HW-1:0] LOAD_END = HW'(2 * N + 2);
  localparam logic [HW-1:0] READ_END = HW'(256);

  generate
    if (K != 128 && K != 192 && K != 256) begin : g_bad_k
      $error("aes_spi_master: K must be 128, 192 or 256");
    end
    if (DIV < 2 || DIV > 255) begin : g_bad_div
      $error("aes_spi_master: DIV must be in 2..255");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_WAIT,
    S_READ,
    S_FIN
  } state_t;

  state_t          state;
  logic [N-1:0]    sreg;
  logic [127:0]    rsr;
  logic [7:0]      div_cnt;
  logic [HW-1:0]   hp;
  logic [HW-1:0]   hp_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      done_sync;
  logic            phase_end;
  logic            done_rise;

  // hp counts SCLK half-phases; a half-phase ends after DIV clk cycles
  always_comb begin
    hp_nxt    = hp + HW'(1);
    phase_end = (div_cnt == 8'(DIV - 1));
    done_rise = done_sync[1] & ~done_sync[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      ce           <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      sreg         <= '0;
      rsr          <= '0;
      div_cnt      <= '0;
      hp           <= '0;
      cnt          <= '0;
      done_sync    <= '0;
    end else begin
      done_sync    <= {done_sync[1:0], done_in};
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg    <= {key, message, 7'b0, dir};
            mosi    <= key[K-1];
            busy    <= 1'b1;
            div_cnt <= '0;
            hp      <= '0;
            state   <= S_LOAD;
          end
        end
        // half-phase 0: settle, 1: ce lead-in, then N x (high, low); mosi moves on falls
        S_LOAD: begin
          if (phase_end) begin
            div_cnt <= '0;
            hp      <= hp_nxt;
            if (hp_nxt == HW'(1)) begin
              ce <= 1'b1;
            end else if (hp_nxt == LOAD_END) begin
              ce    <= 1'b0;
              cnt   <= '0;
              state <= S_GAP;
            end else if (!hp_nxt[0]) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              sreg <= {sreg[N-2:0], 1'b0};
              mosi <= sreg[N-2];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt == CW'(2 * DIV - 1)) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // only a fresh synchronized rising edge of done_in counts
        S_WAIT: begin
          if (done_rise) begin
            div_cnt <= '0;
            hp      <= '0;
            state   <= S_READ;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_READ: begin
          if (phase_end) begin
            div_cnt <= '0;
            hp      <= hp_nxt;
            if (hp_nxt == READ_END) begin
              sclk  <= 1'b0;
              state <= S_FIN;
            end else if (hp_nxt[0]) begin
              sclk <= 1'b1;
              rsr  <= {rsr[126:0], miso};
            end else begin
              sclk <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_FIN: begin
          result       <= rsr;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
